// File: rtl/reg_file_param.sv
// Purpose : parameterised 2-read/1-write register file with byte-masked writes and a sequenced array clear.
// Latency : reads are registered, 1 cycle from address to data; writes land on the sampling edge.
// Backpr. : no valid/ready handshake; ready=0 while the clear sequence runs, and writes are ignored then.
//
// Ports   : clk, rst (sync, active-high) | wr_en, in_addr, in_data, wr_mask (byte enables)
//           addr_r1/addr_r2 -> data_r1/data_r2 (registered) | clr_req -> full clear, ready = array usable
// Option  : define RF_BYPASS_EN to forward a same-cycle write into the read ports
//           (otherwise reads see the pre-write entry).
module reg_file_param #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 6,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [DATA_W/8-1:0] wr_mask,
  input  logic [ADDR_W-1:0]   addr_r1,
  input  logic [ADDR_W-1:0]   addr_r2,
  output logic [DATA_W-1:0]   data_r1,
  output logic [DATA_W-1:0]   data_r2,
  input  logic                clr_req,
  output logic                ready
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int NBYTES = DATA_W / 8;

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   data_r1_q, data_r1_d;
  logic [DATA_W-1:0]   data_r2_q, data_r2_d;

  // Storage is deliberately not reset; the CLEAR walk zeroes it.
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic [DATA_W-1:0]   bit_mask;
  logic                wr_zero;
  logic                wr_fire;
  logic [DATA_W-1:0]   rd1, rd2;

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_v,
                                              input logic [DATA_W-1:0] msk,
                                              input logic [DATA_W-1:0] new_v);
    return (old_v & ~msk) | (new_v & msk);
  endfunction

  // Byte enables expanded to a per-bit mask.
  always_comb begin
    bit_mask = '0;
    for (int b = 0; b < NBYTES; b++) begin
      bit_mask[8*b +: 8] = {8{wr_mask[b]}};
    end
  end

  // A write only takes effect in READY, and loses to a same-cycle clear request
  // and to writes aimed at the hardwired zero entry.
  always_comb begin
    wr_zero = (ZERO_REG != 0) && (in_addr == '0);
    wr_fire = (state_q == ST_READY) && !clr_req && wr_en && !wr_zero;
  end

  // Read muxes. wr_fire already excludes entry 0, so forwarding never
  // overrides the zero-register forcing.
  always_comb begin
    rd1 = mem_q[addr_r1];
    rd2 = mem_q[addr_r2];
    if ((ZERO_REG != 0) && (addr_r1 == '0)) rd1 = '0;
    if ((ZERO_REG != 0) && (addr_r2 == '0)) rd2 = '0;
`ifdef RF_BYPASS_EN
    if (wr_fire && (addr_r1 == in_addr)) rd1 = merge(rd1, bit_mask, in_data);
    if (wr_fire && (addr_r2 == in_addr)) rd2 = merge(rd2, bit_mask, in_data);
`endif
  end

  // Next-state logic; rst is applied in the register block.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ready_d   = ready_q;
    data_r1_d = rd1;
    data_r2_d = rd2;
    case (state_q)
      ST_CLEAR: begin
        // clr_req is ignored here: the walk never restarts except on rst.
        data_r1_d = '0;
        data_r2_d = '0;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1) begin
          state_d = ST_READY;
          ready_d = 1'b1;
        end
      end
      default: begin
        if (clr_req) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
          ready_d   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
      data_r1_q <= '0;
      data_r2_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
      data_r1_q <= data_r1_d;
      data_r2_q <= data_r2_d;
    end
  end

  // Array write port: either the clear walk or a masked user write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_CLEAR) begin
        mem_q[clr_cnt_q] <= '0;
      end else if (wr_fire) begin
        mem_q[in_addr] <= merge(mem_q[in_addr], bit_mask, in_data);
      end
    end
  end

  assign data_r1 = data_r1_q;
  assign data_r2 = data_r2_q;
  assign ready   = ready_q;

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param (DATA_W=64, ADDR_W=6, ZERO_REG=1).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_reg_file_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [5:0]  in_addr;
  logic [63:0] in_data;
  logic [7:0]  wr_mask;
  logic [5:0]  addr_r1;
  logic [5:0]  addr_r2;
  logic [63:0] data_r1;
  logic [63:0] data_r2;
  logic        clr_req;
  logic        ready;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  reg_file_param #(.DATA_W(64), .ADDR_W(6), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .in_addr(in_addr), .in_data(in_data),
    .wr_mask(wr_mask), .addr_r1(addr_r1), .addr_r2(addr_r2), .data_r1(data_r1),
    .data_r2(data_r2), .clr_req(clr_req), .ready(ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until ready rises (bounded); also reports whether any read
  // returned nonzero data while waiting.
  task automatic wait_ready(output int n, output bit nonzero);
    n = 0;
    nonzero = 1'b0;
    for (int i = 0; i < 200; i++) begin
      addr_r1 = 6'(i + 17);
      addr_r2 = 6'(i);
      tick();
      n++;
      if (data_r1 !== 64'd0 || data_r2 !== 64'd0) nonzero = 1'b1;
      if (ready === 1'b1) break;
    end
  endtask

  task automatic test_reset();
    int n;
    bit nz;
    rst = 1'b1;
    tick();
    tick();
    tests++;
    if (ready !== 1'b0 || data_r1 !== 64'd0 || data_r2 !== 64'd0) begin
      fails++;
      $display("FAIL reset_state: ready=%b r1=%h r2=%h, required ready=0 r1=0 r2=0", ready, data_r1, data_r2);
    end
    rst = 1'b0;
    wait_ready(n, nz);
    tests++;
    if (n !== 64) begin
      fails++;
      $display("FAIL reset_ready_latency: %0d edges, required 64", n);
    end
    tests++;
    if (nz !== 1'b0) begin
      fails++;
      $display("FAIL reset_reads_zero: nonzero read seen during clear, required all 0");
    end
    // Array must really be cleared, not just masked during CLEAR.
    addr_r1 = 6'd17;
    addr_r2 = 6'd63;
    tick();
    tests++;
    if (data_r1 !== 64'd0 || data_r2 !== 64'd0) begin
      fails++;
      $display("FAIL post_clear_read: r1=%h r2=%h, required 0 0", data_r1, data_r2);
    end
  endtask

  task automatic test_write_full();
    wr_en = 1'b1; in_addr = 6'd17; in_data = 64'h0123_4567_89AB_CDEF; wr_mask = 8'hFF;
    tick();
    wr_en = 1'b0; addr_r1 = 6'd17;
    tick();
    tests++;
    if (data_r1 !== 64'h0123_4567_89AB_CDEF) begin
      fails++;
      $display("FAIL write_full: got %h, required 0123456789abcdef", data_r1);
    end
  endtask

  task automatic test_byte_mask();
    wr_en = 1'b1; in_addr = 6'd17; in_data = 64'hFFFF_FFFF_FFFF_FFFF; wr_mask = 8'h0F;
    tick();
    wr_en = 1'b0; addr_r1 = 6'd17;
    tick();
    tests++;
    if (data_r1 !== 64'h0123_4567_FFFF_FFFF) begin
      fails++;
      $display("FAIL byte_mask: got %h, required 01234567ffffffff", data_r1);
    end
    // Write with an empty mask must change nothing.
    wr_en = 1'b1; in_addr = 6'd17; in_data = 64'h0; wr_mask = 8'h00;
    tick();
    wr_en = 1'b0; addr_r2 = 6'd17;
    tick();
    tests++;
    if (data_r2 !== 64'h0123_4567_FFFF_FFFF) begin
      fails++;
      $display("FAIL zero_mask: got %h, required 01234567ffffffff", data_r2);
    end
  endtask

  task automatic test_same_cycle();
    logic [63:0] exp_new, exp_part;
`ifdef RF_BYPASS_EN
    exp_new  = 64'hDEAD_BEEF_0000_0001;
    exp_part = 64'h0000_0000_FFFF_FFFF;
`else
    exp_new  = 64'h0;
    exp_part = 64'h0123_4567_FFFF_FFFF;
`endif
    wr_en = 1'b1; in_addr = 6'd22; in_data = 64'hDEAD_BEEF_0000_0001; wr_mask = 8'hFF;
    addr_r1 = 6'd17; addr_r2 = 6'd22;
    tick();
    wr_en = 1'b0;
    tests++;
    if (data_r2 !== exp_new) begin
      fails++;
      $display("FAIL same_cycle_r2: got %h, required %h", data_r2, exp_new);
    end
    tests++;
    if (data_r1 !== 64'h0123_4567_FFFF_FFFF) begin
      fails++;
      $display("FAIL independent_r1: got %h, required 01234567ffffffff", data_r1);
    end
    tick();
    tests++;
    if (data_r2 !== 64'hDEAD_BEEF_0000_0001) begin
      fails++;
      $display("FAIL after_write_r2: got %h, required deadbeef00000001", data_r2);
    end
    // Partial-mask write with a same-cycle read of the same entry on port 1.
    wr_en = 1'b1; in_addr = 6'd17; in_data = 64'h0; wr_mask = 8'hF0;
    addr_r1 = 6'd17; addr_r2 = 6'd22;
    tick();
    wr_en = 1'b0;
    tests++;
    if (data_r1 !== exp_part) begin
      fails++;
      $display("FAIL same_cycle_partial_r1: got %h, required %h", data_r1, exp_part);
    end
    addr_r2 = 6'd17;
    tick();
    tests++;
    if (data_r1 !== 64'h0000_0000_FFFF_FFFF || data_r2 !== 64'h0000_0000_FFFF_FFFF) begin
      fails++;
      $display("FAIL equal_addr: r1=%h r2=%h, required 00000000ffffffff both", data_r1, data_r2);
    end
  endtask

  task automatic test_zero_reg();
    wr_en = 1'b1; in_addr = 6'd0; in_data = 64'h5; wr_mask = 8'hFF;
    addr_r1 = 6'd0; addr_r2 = 6'd0;
    tick();
    wr_en = 1'b0;
    tests++;
    if (data_r1 !== 64'd0 || data_r2 !== 64'd0) begin
      fails++;
      $display("FAIL zero_reg_same: r1=%h r2=%h, required 0 0", data_r1, data_r2);
    end
    tick();
    tests++;
    if (data_r1 !== 64'd0 || data_r2 !== 64'd0) begin
      fails++;
      $display("FAIL zero_reg_after: r1=%h r2=%h, required 0 0", data_r1, data_r2);
    end
    // Top entry boundary.
    wr_en = 1'b1; in_addr = 6'd63; in_data = 64'hA5A5_0000_1111_2222; wr_mask = 8'hFF;
    tick();
    wr_en = 1'b0; addr_r2 = 6'd63;
    tick();
    tests++;
    if (data_r2 !== 64'hA5A5_0000_1111_2222) begin
      fails++;
      $display("FAIL top_entry: got %h, required a5a5000011112222", data_r2);
    end
  endtask

  task automatic test_clear();
    int n;
    bit nz;
    // Clear request with a same-cycle write that must be dropped.
    clr_req = 1'b1; wr_en = 1'b1; in_addr = 6'd30; in_data = 64'h7777; wr_mask = 8'hFF;
    tick();
    clr_req = 1'b0; wr_en = 1'b0;
    tests++;
    if (ready !== 1'b0) begin
      fails++;
      $display("FAIL clr_ready_drop: ready=%b, required 0", ready);
    end
    // A second request mid-clear is ignored: the count must not restart.
    for (int i = 0; i < 5; i++) tick();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    wait_ready(n, nz);
    tests++;
    if (n + 6 !== 64) begin
      fails++;
      $display("FAIL clr_latency: %0d edges, required 64", n + 6);
    end
    addr_r1 = 6'd17; addr_r2 = 6'd30;
    tick();
    tests++;
    if (data_r1 !== 64'd0 || data_r2 !== 64'd0) begin
      fails++;
      $display("FAIL clr_contents: r1=%h r2=%h, required 0 0", data_r1, data_r2);
    end
  endtask

  task automatic test_rst_mid_clear();
    int n;
    bit nz;
    wr_en = 1'b1; in_addr = 6'd9; in_data = 64'h1234; wr_mask = 8'hFF;
    tick();
    wr_en = 1'b0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if (ready !== 1'b0 || data_r1 !== 64'd0) begin
      fails++;
      $display("FAIL rst_mid_clear_state: ready=%b r1=%h, required 0 0", ready, data_r1);
    end
    wait_ready(n, nz);
    tests++;
    if (n !== 64) begin
      fails++;
      $display("FAIL rst_restart_latency: %0d edges, required 64", n);
    end
    addr_r1 = 6'd9;
    tick();
    tests++;
    if (data_r1 !== 64'd0) begin
      fails++;
      $display("FAIL rst_restart_contents: got %h, required 0", data_r1);
    end
    // rst in READY drops ready on that edge.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if (ready !== 1'b0) begin
      fails++;
      $display("FAIL rst_in_ready: ready=%b, required 0", ready);
    end
    wait_ready(n, nz);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; in_addr = '0; in_data = '0; wr_mask = '0;
    addr_r1 = '0; addr_r2 = '0; clr_req = 1'b0;
    #1;
    test_reset();
    test_write_full();
    test_byte_mask();
    test_same_cycle();
    test_zero_reg();
    test_clear();
    test_rst_mid_clear();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 SHALL have parameter DATA_W, default 64, data width in bits, multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 6, address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have parameter ZERO_REG, default 1; when 1, entry 0 reads as 0 and writes to it are discarded.
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port wr_en  input  1  write request.
REQ-007 SHALL have port in_addr  input  ADDR_W  write address.
REQ-008 SHALL have port in_data  input  DATA_W  write data.
REQ-009 SHALL have port wr_mask  input  DATA_W/8  byte enables; bit i enables in_data[8i+7:8i].
REQ-010 SHALL have ports addr_r1, addr_r2  input  ADDR_W  read addresses.
REQ-011 SHALL have ports data_r1, data_r2  output  DATA_W  registered read data.
REQ-012 SHALL have port clr_req  input  1  request a full array clear.
REQ-013 SHALL have port ready  output  1  high when array is usable (state READY).

Function
REQ-014 SHALL implement FSM states CLEAR and READY only.
REQ-015 In CLEAR, SHALL write 0 to entry clr_cnt each edge, then increment clr_cnt, from 0 to DEPTH-1.
REQ-016 On the edge clearing entry DEPTH-1, SHALL go to READY and set ready=1 (ready rises exactly DEPTH edges after the first edge with rst low).
REQ-017 In CLEAR, SHALL ignore wr_en and drive data_r1/data_r2 to 0.
REQ-018 In READY, clr_req=1 at an edge SHALL enter CLEAR with clr_cnt=0 and ready=0 from that edge; a same-cycle write is dropped.
REQ-019 clr_req while in CLEAR SHALL be ignored (no restart of the count).
REQ-020 In READY, wr_en=1 SHALL update only bytes of entry in_addr whose wr_mask bit is 1; others keep their value.
REQ-021 wr_en=1 with wr_mask=0 SHALL leave the array unchanged.
REQ-022 Reads SHALL have 1-cycle latency: data_rN after edge k equals entry addr_rN sampled at edge k.
REQ-023 Both read ports SHALL be independent; equal addresses return identical data.
REQ-024 With ZERO_REG=1, a read of address 0 SHALL return 0 regardless of writes.
REQ-025 Same-cycle write and read of one address SHALL follow REQ-033/REQ-034.

Reset
REQ-026 rst=1 at an edge SHALL set state CLEAR, clr_cnt=0, ready=0, data_r1=data_r2=0.
REQ-027 Array contents SHALL not be cleared by rst directly; clearing is done by the CLEAR sequence.
REQ-028 rst SHALL have priority over clr_req and wr_en; rst asserted mid-CLEAR SHALL restart the count at 0.
REQ-029 rst asserted in READY SHALL abort any write in that cycle.

Configuration
REQ-030 SHALL support macro RF_BYPASS_EN, selecting write-to-read forwarding.
REQ-031 Forwarding SHALL apply only in READY, and only for a write to a nonzero address when ZERO_REG=1.
REQ-032 Forwarding SHALL apply per read port independently.
REQ-033 With RF_BYPASS_EN defined, a same-cycle wr_en to addr_rN SHALL return old entry merged with in_data bytes selected by wr_mask.
REQ-034 Without RF_BYPASS_EN, same-cycle read SHALL return the pre-write entry (read-before-write); the new value is visible from the next read.

Verification
REQ-035 rst high 2 cycles, then low -> ready=0 for 63 edges, ready=1 on edge 64 (ADDR_W=6); all reads return 0.
REQ-036 In READY, write addr 17 = 64'h0123_4567_89AB_CDEF, mask 8'hFF; next cycle read addr_r1=17 -> data_r1=64'h0123_4567_89AB_CDEF one edge later.
REQ-037 Then write addr 17 data 64'hFFFF_FFFF_FFFF_FFFF, mask 8'h0F -> read 17 returns 64'h0123_4567_FFFF_FFFF.
REQ-038 Same cycle: write addr 22 = 64'hDEAD_BEEF_0000_0001, addr_r2=22 -> data_r2 = new value with RF_BYPASS_EN, 0 without.
REQ-039 Write addr 0 = 64'h5, read addr 0 on both ports -> 0 (ZERO_REG=1).
REQ-040 clr_req pulse in READY after REQ-036 -> ready=0 for 64 edges, then read 17 -> 0; rst at clear step 10 -> count restarts, ready after 64 further edges.
